// File: rtl/oam_dma.sv
// Sprite DMA for $4014: halts the CPU, copies one 256-byte page into PPU OAMDATA.
// Build option: define OAM_DMA_ADDR_CLR_EN to zero OAMADDR before the first byte.
module oam_dma #(
    parameter int RD_LAT   = 1,
    parameter int CS_WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_we,
    input  logic [7:0]  dma_page,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_i,
    output logic        ppu_cs,
    output logic        ppu_rw,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_data_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_CLR,
        S_GAP,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [7:0] LAT_LAST = 8'(RD_LAT - 1);
    localparam logic [7:0] CS_LAST  = 8'(CS_WIDTH - 1);

`ifdef OAM_DMA_ADDR_CLR_EN
    localparam state_t FIRST_ST = S_CLR;
`else
    localparam state_t FIRST_ST = S_READ;
`endif

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] idx_reg, idx_next;
    logic [7:0] page_reg, page_next;
    logic [7:0] data_reg, data_next;
    logic       odd_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        page_next  = page_reg;
        data_next  = data_reg;
        case (state_reg)
            S_IDLE: begin
                if (dma_we) begin
                    page_next  = dma_page;
                    idx_next   = 8'd0;
                    state_next = S_HALT;
                end
            end
            S_HALT: begin
                cnt_next   = 8'd0;
                state_next = odd_reg ? S_ALIGN : FIRST_ST;
            end
            S_ALIGN: state_next = FIRST_ST;
            S_CLR: begin
                if (cnt_reg == CS_LAST) begin
                    cnt_next   = 8'd0;
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_GAP: state_next = S_READ;
            S_READ: begin
                cnt_next   = 8'd0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // Memory data is only valid on the final wait cycle.
                if (cnt_reg == LAT_LAST) begin
                    cnt_next   = 8'd0;
                    data_next  = mem_data_i;
                    state_next = S_WRITE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_WRITE: begin
                if (cnt_reg == CS_LAST) begin
                    cnt_next = 8'd0;
                    if (idx_reg == 8'hFF) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx_reg + 8'd1;
                        state_next = S_READ;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DONE: begin
                idx_next   = 8'd0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 8'd0;
            idx_reg    <= 8'd0;
            page_reg   <= 8'd0;
            data_reg   <= 8'd0;
            odd_reg    <= 1'b0;
            cpu_halt   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= 16'h0000;
            ppu_cs     <= 1'b0;
            ppu_rw     <= 1'b1;
            ppu_addr   <= 3'd0;
            ppu_data_o <= 8'h00;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            page_reg   <= page_next;
            data_reg   <= data_next;
            odd_reg    <= ~odd_reg;
            cpu_halt   <= state_next inside {S_HALT, S_ALIGN, S_CLR, S_GAP, S_READ, S_WAIT, S_WRITE};
            busy       <= state_next inside {S_HALT, S_ALIGN, S_CLR, S_GAP, S_READ, S_WAIT, S_WRITE};
            done       <= (state_next == S_DONE);
            mem_rd     <= (state_next == S_READ);
            mem_addr   <= (state_next == S_READ) ? {page_next, idx_next} : 16'h0000;
            ppu_cs     <= state_next inside {S_CLR, S_WRITE};
            ppu_rw     <= !(state_next inside {S_CLR, S_WRITE});
            ppu_addr   <= (state_next == S_WRITE) ? 3'd4 :
                          (state_next == S_CLR)   ? 3'd3 : 3'd0;
            ppu_data_o <= (state_next == S_WRITE) ? data_next : 8'h00;
        end
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side initiator for the PPU register port: implements the $4014 sprite DMA.
- On a trigger, halts the CPU and reads 256 bytes from CPU page {dma_page,8'h00}..{dma_page,8'hFF}.
- Delivers each byte as a register write to PPU OAMDATA (cpu_addr 4), using the cs/rw/addr/data strobes the PPU edge-detects.
- Sits between the CPU memory bus, the CPU RDY logic and the PPU register interface.

Parameters:
- RD_LAT, 1, memory read latency in cycles from the mem_rd cycle until mem_data_i is valid (≥1).
- CS_WIDTH, 1, cycles ppu_cs is held high per register write (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- dma_we  in  1  single-cycle write strobe to $4014
- dma_page  in  8  source page; sampled when dma_we=1
- cpu_halt  out  1  stalls CPU while high
- busy  out  1  high from the HALT state through the last WRITE
- done  out  1  one-cycle pulse when the transfer completes
- mem_rd  out  1  memory read strobe
- mem_addr  out  16  read address
- mem_data_i  in  8  read data, valid RD_LAT cycles after mem_rd
- ppu_cs  out  1  PPU register chip select
- ppu_rw  out  1  1=read, 0=write
- ppu_addr  out  3  PPU register index
- ppu_data_o  out  8  write data to PPU

Behaviour:
- Reset: synchronous. All outputs 0 except ppu_rw=1. State IDLE, idx=0, parity bit odd=0.
- Parity bit odd toggles every cycle while not in reset.
- State sequence: IDLE, HALT, ALIGN, READ, WAIT, WRITE, DONE.
- IDLE:
  - dma_we=1 latches dma_page and goes to HALT next cycle.
  - dma_we in any other state is ignored; the page is not re-latched.
- HALT (1 cycle):
  - cpu_halt=1, busy=1.
  - If odd=1, go to ALIGN; otherwise go to READ.
- ALIGN: 1 idle cycle with cpu_halt=1, then READ.
- READ (1 cycle):
  - mem_rd=1, mem_addr={page,idx}.
  - mem_rd and mem_addr are 0 in all other states.
- WAIT (RD_LAT cycles): on the last WAIT cycle, register mem_data_i into the data latch.
- WRITE (CS_WIDTH cycles):
  - ppu_cs=1, ppu_rw=0, ppu_addr=3'd4, ppu_data_o=latch.
  - Outside WRITE: ppu_cs=0, ppu_rw=1, ppu_data_o=0.
- After WRITE:
  - If idx=8'hFF, go to DONE.
  - Otherwise idx increments mod 256 and the next state is READ.
  - ppu_cs is therefore low for ≥1+RD_LAT cycles between writes, which guarantees a rising edge for every byte.
- DONE (1 cycle):
  - done=1; cpu_halt=0; busy=0.
  - Return to IDLE. dma_we in DONE is ignored.
- cpu_halt=1 in HALT, ALIGN, READ, WAIT, WRITE.
- Timing with defaults, odd=0 at HALT, trigger sampled at edge of cycle 0:
  - HALT at cycle 1.
  - Byte k: READ at 2+3k, WRITE at 4+3k.
  - Last WRITE at 769; DONE at 770.
  - cpu_halt high for cycles 1–769 (769 cycles).
  - ALIGN adds exactly 1 cycle.
- Per-byte period: 2+RD_LAT+CS_WIDTH-1 cycles (1+RD_LAT+CS_WIDTH).
- Page wrap: none; mem_addr[15:8] is constant for the whole transfer.
- Reset mid-transfer:
  - Outputs return to reset values on the next edge; no partial write completes.
  - A subsequent trigger restarts from idx 0.

Optional Feature:
- Macro: OAM_DMA_ADDR_CLR_EN.
- Defined:
  - After HALT/ALIGN and before the first READ, perform one WRITE-shaped access for CS_WIDTH cycles: ppu_addr=3'd3 (OAMADDR), ppu_data_o=8'h00.
  - Follow it with one cycle of ppu_cs=0, then the normal sequence.
  - Adds CS_WIDTH+1 cycles (default 2: DONE at 772).
- Undefined: no OAMADDR access; the transfer starts at the current OAMADDR.

Test Plan:
- Basic transfer:
  - Stimulus: defaults, odd=0 at HALT, dma_page=8'h02, memory returns addr[7:0]^8'hA5.
  - Required: exactly 256 writes to ppu_addr 4 with data 8'hA5,8'hA4,…,8'h5A, in order.
  - Required: each ppu_cs pulse is 1 cycle wide, followed by 2 low cycles; mem_addr runs 16'h0200..16'h02FF.
  - Required: done at cycle 770; cpu_halt high for 769 cycles.
- Alignment: same as Basic transfer but odd=1 at HALT -> one ALIGN cycle; first READ at cycle 3; done at cycle 771.
- Retrigger ignored:
  - Stimulus: dma_we with dma_page=8'h07 at byte 50, and again during DONE.
  - Required: mem_addr[15:8] stays 8'h02 throughout; done pulses once; IDLE afterwards.
- Reset mid-transfer:
  - Stimulus: assert rst during the WRITE of byte 100.
  - Required: next cycle ppu_cs=0, cpu_halt=0, busy=0, ppu_rw=1.
  - Required: a new trigger with page 8'h03 restarts at mem_addr 16'h0300.
- Parameters:
  - Stimulus: RD_LAT=3, CS_WIDTH=2.
  - Required: per-byte period 6 cycles; ppu_cs high exactly 2 cycles per byte.
  - Required: data captured matches memory; done at cycle 1+6·256+1=1538.
- Feature on:
  - Stimulus: OAM_DMA_ADDR_CLR_EN defined.
  - Required: the first ppu_cs pulse has ppu_addr=3 and data 8'h00, followed by 256 writes to ppu_addr 4.
  - Required: done at cycle 772 with defaults and odd=0.
